// File: rtl/packet_repacker.sv
// Word-to-packet repacker: packs IN_W-bit words MSB-first into a reservoir and
// emits PKT_W-bit packets, with backpressure on both sides and a zero-padded flush.
module packet_repacker #(
  parameter int IN_W  = 32,
  parameter int PKT_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  data,
  input  logic             datavalid,
  output logic             dready,
  input  logic             flush,
  output logic [PKT_W-1:0] packetdata,
  output logic             pvalid,
  input  logic             pready,
  output logic             plast,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int BUF_W  = PKT_W + IN_W - 1;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] PKT_F = FILL_W'(PKT_W);
  localparam logic [FILL_W-1:0] IN_F  = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] BUF_F = FILL_W'(BUF_W);
  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [BUF_W-1:0]  buf_q, buf_d, buf_pop, word_ext;
  logic [FILL_W-1:0] fill_q, fill_d, fill_pop;
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic              pop, accept;

  assign pvalid     = (fill_q >= PKT_F) || (state_q == S_FLUSH && fill_q != '0);
  assign plast      = (state_q == S_FLUSH) && (fill_q <= PKT_F);
  assign packetdata = buf_q[BUF_W-1 -: PKT_W];
  assign dready     = (state_q == S_FILL) && (!pvalid || pready);
  assign pop        = pvalid && pready;
  assign accept     = datavalid && dready;
  assign pkt_count  = pkt_count_q;
  assign word_ext   = BUF_W'(data) << (BUF_W - IN_W);

  always_comb begin
    // Bits below fill are always zero, so a short residue pads itself.
    buf_pop  = pop ? (buf_q << PKT_W) : buf_q;
    fill_pop = pop ? ((fill_q >= PKT_F) ? fill_q - PKT_F : '0) : fill_q;
    buf_d    = buf_pop;
    fill_d   = fill_pop;
    if (accept) begin
      buf_d  = buf_pop | (word_ext >> fill_pop);
      fill_d = fill_pop + IN_F;
    end
    state_d = state_q;
    if (state_q == S_FILL) begin
      if (flush && fill_d != '0) state_d = S_FLUSH;
    end else if (pop && fill_pop == '0) begin
      state_d = S_FILL;
    end
    pkt_count_d = pkt_count_q + CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q       <= '0;
      fill_q      <= '0;
      state_q     <= S_FILL;
      pkt_count_q <= '0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (fill_q <= BUF_F);
  end
endmodule

// File: tb/tb_packet_repacker.sv
// Bench for packet_repacker: directed scenarios with fixed expectations, then a
// randomized run against a bit-queue reference model.
module tb_packet_repacker;
  localparam int IN_W  = 32;
  localparam int PKT_W = 48;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [IN_W-1:0]  data = '0;
  logic             datavalid = 1'b0;
  logic             dready;
  logic             flush = 1'b0;
  logic [PKT_W-1:0] packetdata;
  logic             pvalid;
  logic             pready = 1'b0;
  logic             plast;
  logic [CNT_W-1:0] pkt_count;

  int checks = 0;
  int errors = 0;

  // Reference model: stream of pending bits, flushing flag, packet count.
  bit          mq[$];
  bit          mflush = 1'b0;
  int unsigned mcount = 0;

  packet_repacker #(.IN_W(IN_W), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .data(data), .datavalid(datavalid), .dready(dready),
    .flush(flush), .packetdata(packetdata), .pvalid(pvalid), .pready(pready),
    .plast(plast), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic bit m_pvalid();
    return (mq.size() >= PKT_W) || (mflush && mq.size() > 0);
  endfunction

  function automatic logic [PKT_W-1:0] m_packet();
    logic [PKT_W-1:0] p = '0;
    for (int i = 0; i < PKT_W; i++) p[PKT_W-1-i] = (i < mq.size()) ? mq[i] : 1'b0;
    return p;
  endfunction

  function automatic bit m_plast();
    return mflush && (mq.size() <= PKT_W);
  endfunction

  function automatic bit m_dready(input bit pr);
    return !mflush && (!m_pvalid() || pr);
  endfunction

  task automatic apply(input logic dv, input logic [IN_W-1:0] d, input logic fl, input logic pr);
    datavalid = dv; data = d; flush = fl; pready = pr;
    #1;
  endtask

  // Advance one clock; the model follows the same edge using the inputs held across it.
  task automatic tick();
    bit pop, acc;
    pop = m_pvalid() && pready;
    acc = datavalid && m_dready(pready);
    @(posedge clk);
    if (reset) begin
      mq.delete(); mflush = 1'b0; mcount = 0;
    end else begin
      if (pop) begin
        for (int i = 0; i < PKT_W && mq.size() > 0; i++) void'(mq.pop_front());
        mcount++;
      end
      if (acc) for (int i = IN_W - 1; i >= 0; i--) mq.push_back(data[i]);
      if (mflush) begin
        if (mq.size() == 0) mflush = 1'b0;
      end else if (flush && mq.size() > 0) begin
        mflush = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(0, '0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(0, '0, 0, 0);
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL reset_pvalid got %b exp 0", pvalid); end
    checks++; if (plast !== 1'b0) begin errors++; $display("FAIL reset_plast got %b exp 0", plast); end
    checks++; if (packetdata !== '0) begin errors++; $display("FAIL reset_packetdata got %h exp 0", packetdata); end
    checks++; if (dready !== 1'b1) begin errors++; $display("FAIL reset_dready got %b exp 1", dready); end
    checks++; if (pkt_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", pkt_count); end
  endtask

  task automatic test_basic_pack();
    logic [IN_W-1:0] w[3] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, w[i], 0, 1);
      checks++; if (dready !== 1'b1) begin errors++; $display("FAIL basic_dready%0d got %b exp 1", i, dready); end
      if (i == 2) begin
        checks++;
        if (pvalid !== 1'b1 || packetdata !== 48'hAAAAAAAABBBB || plast !== 1'b0) begin
          errors++; $display("FAIL basic_pkt0 got v=%b d=%h l=%b exp v=1 d=aaaaaaaabbbb l=0", pvalid, packetdata, plast);
        end
      end
      tick();
    end
    apply(0, '0, 0, 1);
    checks++;
    if (pvalid !== 1'b1 || packetdata !== 48'hBBBBCCCCCCCC || plast !== 1'b0) begin
      errors++; $display("FAIL basic_pkt1 got v=%b d=%h l=%b exp v=1 d=bbbbcccccccc l=0", pvalid, packetdata, plast);
    end
    tick();
    apply(0, '0, 0, 1);
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", pvalid); end
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", pkt_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    apply(1, 32'hAAAAAAAA, 0, 0); tick();
    apply(1, 32'hBBBBBBBB, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      apply(1, 32'hCCCCCCCC, 0, 0);
      checks++;
      if (pvalid !== 1'b1 || packetdata !== 48'hAAAAAAAABBBB || dready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%b d=%h r=%b exp v=1 d=aaaaaaaabbbb r=0", i, pvalid, packetdata, dready);
      end
      tick();
    end
    apply(1, 32'hCCCCCCCC, 0, 1);
    checks++; if (dready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", dready); end
    tick();
    apply(0, '0, 0, 1);
    checks++; if (packetdata !== 48'hBBBBCCCCCCCC) begin errors++; $display("FAIL bp_pkt1 got %h exp bbbbcccccccc", packetdata); end
    tick();
    apply(0, '0, 0, 1);
    checks++; if (pkt_count !== 16'd2 || pvalid !== 1'b0) begin errors++; $display("FAIL bp_count got %0d v=%b exp 2 v=0", pkt_count, pvalid); end
  endtask

  task automatic test_flush();
    // Padded flush, held once under backpressure.
    do_reset();
    apply(1, 32'h11111111, 0, 1); tick();
    apply(0, '0, 1, 0);
    checks++; if (pvalid !== 1'b0) begin errors++; $display("FAIL pad_preflush got %b exp 0", pvalid); end
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, '0, 0, i);
      checks++;
      if (pvalid !== 1'b1 || packetdata !== 48'h111111110000 || plast !== 1'b1 || dready !== 1'b0) begin
        errors++; $display("FAIL pad_pkt%0d got v=%b d=%h l=%b r=%b exp v=1 d=111111110000 l=1 r=0", i, pvalid, packetdata, plast, dready);
      end
      tick();
    end
    apply(0, '0, 0, 1);
    checks++; if (pvalid !== 1'b0 || plast !== 1'b0 || dready !== 1'b1 || pkt_count !== 16'd1) begin
      errors++; $display("FAIL pad_after got v=%b l=%b r=%b c=%0d exp 0 0 1 1", pvalid, plast, dready, pkt_count);
    end
    // Exact flush: second packet is the last one.
    do_reset();
    apply(1, 32'hAAAAAAAA, 0, 1); tick();
    apply(1, 32'hBBBBBBBB, 0, 1); tick();
    apply(1, 32'hCCCCCCCC, 0, 1); tick();
    apply(0, '0, 1, 0);
    checks++; if (plast !== 1'b0 || pvalid !== 1'b1) begin errors++; $display("FAIL exact_pre got l=%b v=%b exp l=0 v=1", plast, pvalid); end
    tick();
    apply(0, '0, 0, 1);
    checks++; if (packetdata !== 48'hBBBBCCCCCCCC || plast !== 1'b1) begin
      errors++; $display("FAIL exact_last got d=%h l=%b exp d=bbbbcccccccc l=1", packetdata, plast);
    end
    tick();
    apply(0, '0, 1, 1);
    checks++; if (pvalid !== 1'b0 || pkt_count !== 16'd2) begin errors++; $display("FAIL exact_after got v=%b c=%0d exp 0 2", pvalid, pkt_count); end
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, '0, 0, 1);
      checks++; if (pvalid !== 1'b0 || plast !== 1'b0 || dready !== 1'b1) begin
        errors++; $display("FAIL empty_flush%0d got v=%b l=%b r=%b exp 0 0 1", i, pvalid, plast, dready);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    apply(1, 32'hAAAAAAAA, 0, 1); tick();
    apply(1, 32'hBBBBBBBB, 0, 1); tick();
    apply(1, 32'hCCCCCCCC, 0, 1); tick();
    apply(1, 32'hDDDDDDDD, 1, 1);
    checks++; if (dready !== 1'b1 || packetdata !== 48'hBBBBCCCCCCCC || plast !== 1'b0) begin
      errors++; $display("FAIL sim_pop got r=%b d=%h l=%b exp r=1 d=bbbbcccccccc l=0", dready, packetdata, plast);
    end
    tick();
    apply(0, '0, 0, 1);
    checks++; if (pvalid !== 1'b1 || packetdata !== 48'hDDDDDDDD0000 || plast !== 1'b1 || dready !== 1'b0) begin
      errors++; $display("FAIL sim_residue got v=%b d=%h l=%b r=%b exp 1 dddddddd0000 1 0", pvalid, packetdata, plast, dready);
    end
    tick();
    apply(0, '0, 0, 1);
    checks++; if (pvalid !== 1'b0 || pkt_count !== 16'd3) begin errors++; $display("FAIL sim_count got v=%b c=%0d exp 0 3", pvalid, pkt_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(1, 32'hAAAAAAAA, 0, 1); tick();
    do_reset();
    apply(0, '0, 0, 0);
    checks++; if (pvalid !== 1'b0 || plast !== 1'b0 || dready !== 1'b1 || pkt_count !== '0) begin
      errors++; $display("FAIL rst32 got v=%b l=%b r=%b c=%0d exp 0 0 1 0", pvalid, plast, dready, pkt_count);
    end
    apply(1, 32'hAAAAAAAA, 0, 1); tick();
    apply(1, 32'hBBBBBBBB, 0, 1); tick();
    apply(1, 32'hCCCCCCCC, 1, 1); tick();
    do_reset();
    apply(0, '0, 0, 0);
    checks++; if (pvalid !== 1'b0 || plast !== 1'b0 || dready !== 1'b1 || pkt_count !== '0) begin
      errors++; $display("FAIL rst_valid got v=%b l=%b r=%b c=%0d exp 0 0 1 0", pvalid, plast, dready, pkt_count);
    end
    apply(1, 32'h12345678, 0, 1); tick();
    apply(1, 32'h9ABCDEF0, 0, 1); tick();
    apply(0, '0, 0, 0);
    checks++; if (pvalid !== 1'b1 || packetdata !== 48'h123456789ABC || plast !== 1'b0) begin
      errors++; $display("FAIL rst_repack got v=%b d=%h l=%b exp 1 123456789abc 0", pvalid, packetdata, plast);
    end
  endtask

  task automatic test_random();
    logic            dv = 1'b0, fl, pr, hold = 1'b0;
    logic [IN_W-1:0] d = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        dv = ($urandom_range(0, 9) < 7);
        d  = IN_W'($urandom());
      end
      fl = ($urandom_range(0, 19) == 0);
      pr = ($urandom_range(0, 9) < 7);
      apply(dv, d, fl, pr);
      checks++; if (pvalid !== m_pvalid()) begin errors++; $display("FAIL rnd_pvalid c=%0d got %b exp %b", c, pvalid, m_pvalid()); end
      checks++; if (dready !== m_dready(pr)) begin errors++; $display("FAIL rnd_dready c=%0d got %b exp %b", c, dready, m_dready(pr)); end
      checks++; if (pkt_count !== CNT_W'(mcount)) begin errors++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, pkt_count, CNT_W'(mcount)); end
      if (m_pvalid()) begin
        checks++; if (packetdata !== m_packet()) begin errors++; $display("FAIL rnd_data c=%0d got %h exp %h", c, packetdata, m_packet()); end
        checks++; if (plast !== m_plast()) begin errors++; $display("FAIL rnd_plast c=%0d got %b exp %b", c, plast, m_plast()); end
      end
      hold = dv && !m_dready(pr);
      tick();
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic_pack();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
